// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, state encoding, operand payload.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned CNT_W  = 8;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; prio names the favoured client.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       grant_c,
    output logic       valid_c
);

    // Favoured client wins when requesting, otherwise the other one.
    assign valid_c = |req;
    assign grant_c = req[prio] ? prio : ~prio;

endmodule

// File: rtl/alu_sched.sv
// Two-client scheduler for the shared ALU with a completion watchdog.
module alu_sched
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [DATA_W-1:0]    a0,
    input  logic [DATA_W-1:0]    b0,
    input  logic [OP_W-1:0]      op0,
    input  logic [DATA_W-1:0]    a1,
    input  logic [DATA_W-1:0]    b1,
    input  logic [OP_W-1:0]      op1,
    output logic [1:0]           ack,
    output logic [RES_W-1:0]     result,
    output logic                 err,
    output logic                 busy,
    output logic                 alu_start,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [OP_W-1:0]      alu_op,
    input  logic [RES_W-1:0]     alu_result,
    input  logic                 alu_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_e       state_q, state_d;
    logic               prio_q, prio_d;
    logic               grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         ack_d;
    logic [RES_W-1:0]   result_d;
    logic               err_d;
    logic               busy_d;
    logic               alu_start_d;
    alu_req_t           issue_q, issue_d;
    alu_req_t           cand;
    logic               arb_grant;
    logic               arb_valid;

    rr_arb2 u_arb (
        .req     (req),
        .prio    (prio_q),
        .grant_c (arb_grant),
        .valid_c (arb_valid)
    );

    assign alu_a  = issue_q.a;
    assign alu_b  = issue_q.b;
    assign alu_op = issue_q.op;

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        ack_d       = 2'b00;
        result_d    = result;
        err_d       = err;
        alu_start_d = 1'b0;
        issue_d     = issue_q;
        cand        = arb_grant ? alu_req_t'{a: a1, b: b1, op: op1}
                                : alu_req_t'{a: a0, b: b0, op: op0};

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    issue_d     = cand;
                    grant_d     = arb_grant;
                    alu_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done beats a same-cycle timeout.
                if (alu_done) begin
                    result_d = alu_result;
                    err_d    = 1'b0;
                    ack_d    = grant_q ? 2'b10 : 2'b01;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    ack_d    = grant_q ? 2'b10 : 2'b01;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                prio_d  = ~grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            grant_q   <= 1'b0;
            cnt_q     <= '0;
            ack       <= 2'b00;
            result    <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            alu_start <= 1'b0;
            issue_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            ack       <= ack_d;
            result    <= result_d;
            err       <= err_d;
            busy      <= busy_d;
            alu_start <= alu_start_d;
            issue_q   <= issue_d;
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched with a behavioural ALU of programmable latency.
module tb_alu_sched;
    import alu_pkg::*;

    localparam int unsigned TIMEOUT = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  a0, b0, a1, b1;
    logic [1:0]  op0, op1;
    logic [1:0]  ack;
    logic [15:0] result;
    logic        err;
    logic        busy;
    logic        alu_start;
    logic [7:0]  alu_a, alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_done;

    alu_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a0(a0), .b0(b0), .op0(op0),
        .a1(a1), .b1(b1), .op1(op1),
        .ack(ack), .result(result), .err(err), .busy(busy),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  ack;
        logic [15:0] res;
        logic        err;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // ALU model: done_wait = index of the WAIT cycle carrying done, -1 = never.
    int done_wait = -1;
    int wcnt = 0;
    bit pending = 0;

    function automatic logic [15:0] alu_model(logic [7:0] a, logic [7:0] b, logic [1:0] op);
        logic signed [15:0] sa, sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        case (op)
            OP_ADD:  return 16'(sa + sb);
            OP_SUB:  return 16'(sa - sb);
            OP_MUL:  return 16'(sa * sb);
            default: return (sb == 16'sd0) ? 16'hFFFF : 16'(sa / sb);
        endcase
    endfunction

    always @(negedge clk) begin
        alu_done = 1'b0;
        if (rst === 1'b1) begin
            pending = 0;
        end else if (alu_start === 1'b1) begin
            pending    = 1;
            wcnt       = 0;
            alu_result = alu_model(alu_a, alu_b, alu_op);
        end else if (pending) begin
            if (done_wait >= 0 && wcnt == done_wait) begin
                alu_done = 1'b1;
                pending  = 0;
            end
            wcnt++;
        end
    end

    // Completion monitor: every ack pops one expectation.
    always @(negedge clk) begin
        if ((|ack) === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_ack: ack=%b result=%h err=%b, required no ack", ack, result, err);
            end else begin
                mon_e = sbq.pop_front();
                if (ack !== mon_e.ack || result !== mon_e.res || err !== mon_e.err) begin
                    bad++;
                    $display("FAIL sb_completion: ack=%b result=%h err=%b, required ack=%b result=%h err=%b",
                             ack, result, err, mon_e.ack, mon_e.res, mon_e.err);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy=%b, required 0 within 100 cycles", busy);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({ack, result, err, busy, alu_start} !== 21'd0) begin
            bad++;
            $display("FAIL %s_ctrl: ack=%b result=%h err=%b busy=%b start=%b, required all 0",
                     tag, ack, result, err, busy, alu_start);
        end
        total++;
        if ({alu_a, alu_b, alu_op} !== 18'd0) begin
            bad++;
            $display("FAIL %s_alu: a=%h b=%h op=%b, required all 0", tag, alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_single_add();
        a0 = 8'd5; b0 = 8'd3; op0 = OP_ADD; done_wait = 1;
        sbq.push_back('{2'b01, 16'h0008, 1'b0});
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        total++;
        if (alu_start !== 1'b1) begin bad++; $display("FAIL add_start_c1: start=%b, required 1", alu_start); end
        @(negedge clk);
        total++;
        if (alu_start !== 1'b0) begin bad++; $display("FAIL add_start_c2: start=%b, required 0", alu_start); end
        @(negedge clk);
        total++;
        if (ack !== 2'b00) begin bad++; $display("FAIL add_ack_c3: ack=%b, required 00", ack); end
        @(negedge clk);
        total++;
        if (ack !== 2'b01 || result !== 16'h0008 || err !== 1'b0) begin
            bad++;
            $display("FAIL add_ack_c4: ack=%b result=%h err=%b, required 01 0008 0", ack, result, err);
        end
        wait_idle();
    endtask

    task automatic test_contention();
        int n = 0;
        int last = 0;
        do_reset();
        a0 = 8'd7; b0 = 8'd6; op0 = OP_MUL;
        a1 = 8'd9; b1 = 8'd4; op1 = OP_SUB;
        done_wait = 0;
        for (int i = 0; i < 2; i++) begin
            sbq.push_back('{2'b01, 16'h002A, 1'b0});
            sbq.push_back('{2'b10, 16'h0005, 1'b0});
        end
        req = 2'b11;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((|ack) === 1'b1) begin
                n++;
                if (n > 1) begin
                    total++;
                    if (cyc - last != 4) begin
                        bad++;
                        $display("FAIL rr_spacing: %0d cycles between acks, required 4", cyc - last);
                    end
                end
                last = cyc;
                if (n == 4) begin
                    req = 2'b00;
                    break;
                end
            end
        end
        total++;
        if (n != 4) begin bad++; $display("FAIL rr_count: %0d acks, required 4", n); end
        wait_idle();
    endtask

    task automatic run_timed(input string tag, input logic [1:0] r);
        int s = -1;
        int e = -1;
        req = r;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (alu_start === 1'b1) begin
                s = cyc;
                req = 2'b00;
            end
            if ((|ack) === 1'b1) begin
                e = cyc;
                break;
            end
        end
        total++;
        if (s < 0 || e < 0 || e - s != int'(TIMEOUT) + 1) begin
            bad++;
            $display("FAIL %s_latency: start->ack %0d cycles (start=%0d ack=%0d), required %0d",
                     tag, e - s, s, e, TIMEOUT + 1);
        end
        wait_idle();
    endtask

    task automatic test_timeout();
        a1 = 8'd100; b1 = 8'd7; op1 = OP_DIV; done_wait = -1;
        sbq.push_back('{2'b10, 16'h0000, 1'b1});
        run_timed("timeout", 2'b10);
    endtask

    task automatic test_collision();
        a0 = 8'hFD; b0 = 8'd100; op0 = OP_ADD; done_wait = int'(TIMEOUT) - 1;
        sbq.push_back('{2'b01, 16'h0061, 1'b0});
        run_timed("collision", 2'b01);
    endtask

    task automatic test_reset_mid();
        int nack = 0;
        bit started = 0;
        a0 = 8'd2; b0 = 8'd2; op0 = OP_ADD; done_wait = -1;
        req = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (alu_start === 1'b1) begin started = 1; req = 2'b00; break; end
        end
        total++;
        if (!started) begin bad++; $display("FAIL rstmid_start: no start pulse, required one"); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rstmid");
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((|ack) === 1'b1) nack++;
        end
        total++;
        if (nack != 0) begin bad++; $display("FAIL rstmid_noack: %0d acks, required 0", nack); end
        a0 = 8'd3; b0 = 8'd4; op0 = OP_ADD;
        a1 = 8'd10; b1 = 8'd1; op1 = OP_SUB;
        done_wait = 0;
        sbq.push_back('{2'b01, 16'h0007, 1'b0});
        req = 2'b11;
        @(negedge clk);
        req = 2'b00;
        total++;
        if (alu_start !== 1'b1 || alu_a !== 8'd3) begin
            bad++;
            $display("FAIL rstmid_prio: start=%b alu_a=%0d, required 1 and 3", alu_start, alu_a);
        end
        wait_idle();
    endtask

    task automatic test_input_change();
        int badc = 0;
        bit seen = 0;
        a0 = 8'd1; b0 = 8'd2; op0 = OP_ADD; done_wait = 2;
        sbq.push_back('{2'b01, 16'h0003, 1'b0});
        req = 2'b01;
        @(negedge clk);
        a0 = 8'd99;
        req = 2'b00;
        for (int i = 0; i < 20; i++) begin
            if (alu_a !== 8'd1) badc++;
            if ((|ack) === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        total++;
        if (badc != 0 || !seen) begin
            bad++;
            $display("FAIL hold_operand: %0d cycles with alu_a!=1, ack_seen=%0d, required 0 and 1", badc, seen);
        end
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; req = 2'b00;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        alu_result = '0; alu_done = 1'b0;
        test_reset();
        test_single_add();
        test_contention();
        test_timeout();
        test_collision();
        test_reset_mid();
        test_input_change();
        repeat (3) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d expectations unconsumed, required 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required finish");
        $fatal(1, "bench timeout");
    end

endmodule
